// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single shared memory port.
// Define MEM_ARB_RR_EN for round-robin on contention; by default data wins.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall
);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD, StDone} state_e;

  state_e state_q, state_d;
  logic   served_data_q;
  logic   grant_any, grant_data, load_grant;

  assign grant_any  = if_req | d_req;
  assign load_grant = (state_q == StIdle) & grant_any;

`ifdef MEM_ARB_RR_EN
  logic last_data_q;

  // On contention, grant whichever side was not granted last.
  assign grant_data = d_req & (~if_req | ~last_data_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data_q <= 1'b1;
    end else if (load_grant) begin
      last_data_q <= grant_data;
    end
  end
`else
  assign grant_data = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          state_d = grant_data ? StBusyD : StBusyIf;
        end
      end
      StBusyIf, StBusyD: begin
        if (mem_ready) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    if_ack  = 1'b0;
    d_ack   = 1'b0;
    unique case (state_q)
      StBusyIf, StBusyD: mem_req = 1'b1;
      StDone: begin
        if_ack = ~served_data_q;
        d_ack  = served_data_q;
      end
      default: ;
    endcase
  end

  // Memory-side command is latched on grant and held for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      served_data_q <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      if_rdata      <= '0;
      d_rdata       <= '0;
    end else begin
      if (load_grant) begin
        served_data_q <= grant_data;
        mem_addr      <= grant_data ? d_addr : if_addr;
        mem_we        <= grant_data & d_we;
        mem_wdata     <= grant_data ? d_wdata : '0;
      end
      if ((state_q == StBusyIf) && mem_ready) begin
        if_rdata <= mem_rdata;
      end
      if ((state_q == StBusyD) && mem_ready && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, stall;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " if_ack"}, {31'd0, if_ack}, 32'd0);
    chk({tag, " d_ack"}, {31'd0, d_ack}, 32'd0);
    chk({tag, " if_rdata"}, if_rdata, 32'd0);
    chk({tag, " d_rdata"}, d_rdata, 32'd0);
  endtask

  // Transaction-level model: one access at most, described by its record.
  bit          acc_active, acc_acked, acc_is_d, acc_we, last_d;
  logic [31:0] acc_addr, acc_wdata, exp_if_rd, exp_d_rd;

  task automatic model_reset();
    acc_active = 0; acc_acked = 0; acc_is_d = 0; acc_we = 0; last_d = 1;
    acc_addr = 0; acc_wdata = 0; exp_if_rd = 0; exp_d_rd = 0;
  endtask

  task automatic model_step();
    bit pick_d;
    if (acc_acked) begin
      acc_acked = 0;
    end else if (acc_active) begin
      if (mem_ready) begin
        if (!acc_is_d) exp_if_rd = mem_rdata;
        else if (!acc_we) exp_d_rd = mem_rdata;
        acc_active = 0;
        acc_acked  = 1;
      end
    end else if (if_req || d_req) begin
      pick_d     = d_req && (!if_req || !RrEn || !last_d);
      last_d     = pick_d;
      acc_is_d   = pick_d;
      acc_addr   = pick_d ? d_addr : if_addr;
      acc_we     = pick_d && d_we;
      acc_wdata  = pick_d ? d_wdata : 32'd0;
      acc_active = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_if, seen_d, e_if, e_d, e_stall;
    int k;
    rst = 1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0;

    // Fetch only, ready in first busy cycle
    if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h8C22_0004;
    @(negedge clk);
    chk("f0 mem_req", {31'd0, mem_req}, 0);
    chk("f0 stall", {31'd0, stall}, 1);
    tick();
    @(negedge clk);
    chk("f1 mem_req", {31'd0, mem_req}, 1);
    chk("f1 mem_addr", mem_addr, 32'h40);
    chk("f1 mem_we", {31'd0, mem_we}, 0);
    chk("f1 if_ack", {31'd0, if_ack}, 0);
    tick();
    @(negedge clk);
    chk("f2 if_ack", {31'd0, if_ack}, 1);
    chk("f2 if_rdata", if_rdata, 32'h8C22_0004);
    chk("f2 mem_req", {31'd0, mem_req}, 0);
    chk("f2 stall", {31'd0, stall}, 0);
    tick();
    if_req = 0; mem_ready = 0;
    @(negedge clk);
    chk("f3 if_ack", {31'd0, if_ack}, 0);

    // Store with three busy cycles
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) mem_ready = 1;
      @(negedge clk);
      chk("st mem_req", {31'd0, mem_req}, 1);
      chk("st mem_we", {31'd0, mem_we}, 1);
      chk("st mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st mem_addr", mem_addr, 32'h100);
      chk("st d_ack early", {31'd0, d_ack}, 0);
      tick();
    end
    mem_ready = 0;
    @(negedge clk);
    chk("st d_ack", {31'd0, d_ack}, 1);
    chk("st d_rdata kept", d_rdata, 32'd0);
    tick();
    d_req = 0; d_we = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st single ack", {31'd0, d_ack}, 0);
      tick();
    end

    // Spurious ready while idle
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sp if_ack", {31'd0, if_ack}, 0);
      chk("sp d_ack", {31'd0, d_ack}, 0);
      chk("sp mem_req", {31'd0, mem_req}, 0);
      chk("sp if_rdata", if_rdata, 32'h8C22_0004);
      chk("sp d_rdata", d_rdata, 32'd0);
      tick();
    end

    // Contention, each side drops after its ack
    rst = 1; #1; rst = 0;
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
    mem_ready = 1; mem_rdata = 32'hA5A5_0001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("ct if_ack", {31'd0, if_ack}, {31'd0, c == (RrEn ? 2 : 5)});
      chk("ct d_ack", {31'd0, d_ack}, {31'd0, c == (RrEn ? 5 : 2)});
      chk("ct stall", {31'd0, stall}, {31'd0, c < 5});
      if (c == 1) chk("ct first addr", mem_addr, RrEn ? 32'h200 : 32'h300);
      seen_if = if_ack; seen_d = d_ack;
      tick();
      if (seen_if) if_req = 0;
      if (seen_d) d_req = 0;
    end

    // Both held continuously: grant order after reset
    rst = 1; #1; rst = 0;
    if_req = 1; d_req = 1; mem_ready = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      k = c / 3;
      e_d  = (c % 3 == 2) && (RrEn ? (k % 2 == 1) : 1'b1);
      e_if = (c % 3 == 2) && !e_d;
      chk("rr if_ack", {31'd0, if_ack}, {31'd0, e_if});
      chk("rr d_ack", {31'd0, d_ack}, {31'd0, e_d});
      tick();
    end
    if_req = 0; d_req = 0; mem_ready = 0;

    // Async reset in the middle of a data access
    rst = 1; #1; rst = 0;
    d_req = 1; d_we = 0; d_addr = 32'h44; mem_rdata = 32'h0BAD_F00D;
    tick();
    @(negedge clk);
    chk("ar busy", {31'd0, mem_req}, 1);
    #2 rst = 1;
    #1 chk_all_zero("ar");
    rst = 0;
    tick();
    d_req = 0; mem_ready = 1;
    @(negedge clk);
    chk("ar regrant", {31'd0, mem_req}, 1);
    chk("ar no ack", {31'd0, d_ack}, 0);
    tick();
    mem_ready = 0;
    @(negedge clk);
    chk("ar dropped ack", {31'd0, d_ack}, 1);
    chk("ar d_rdata", d_rdata, 32'h0BAD_F00D);
    tick();

    // Randomized traffic against the model
    rst = 1; #1; rst = 0;
    model_reset();
    seen_if = 0; seen_d = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      e_if    = acc_acked && !acc_is_d;
      e_d     = acc_acked && acc_is_d;
      e_stall = (if_req && !e_if) || (d_req && !e_d);
      chk("rnd mem_req", {31'd0, mem_req}, {31'd0, acc_active});
      chk("rnd mem_addr", mem_addr, acc_addr);
      chk("rnd mem_we", {31'd0, mem_we}, {31'd0, acc_we});
      chk("rnd mem_wdata", mem_wdata, acc_wdata);
      chk("rnd if_ack", {31'd0, if_ack}, {31'd0, e_if});
      chk("rnd d_ack", {31'd0, d_ack}, {31'd0, e_d});
      chk("rnd if_rdata", if_rdata, exp_if_rd);
      chk("rnd d_rdata", d_rdata, exp_d_rd);
      chk("rnd stall", {31'd0, stall}, {31'd0, e_stall});
      chk("rnd ack excl", {31'd0, if_ack & d_ack}, 32'd0);
      seen_if = if_ack; seen_d = d_ack;
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1;
        #1 chk_all_zero("rnd rst");
        rst = 0;
        model_reset();
        seen_if = 0; seen_d = 0;
      end
      @(posedge clk);
      model_step();
      #1;
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = $urandom;
        end
      end else if (seen_if) begin
        if ($urandom_range(0, 1) == 0) if_req = 0;
        else if_addr = $urandom;
      end else if (acc_active && !acc_is_d && $urandom_range(0, 19) == 0) begin
        if_req = 0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (seen_d) begin
        if ($urandom_range(0, 1) == 0) begin
          d_req = 0;
        end else begin
          d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
        end
      end else if (acc_active && acc_is_d && $urandom_range(0, 19) == 0) begin
        d_req = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
